// File: rtl/diamonds_ctrl.sv
// -----------------------------------------------------------------------------
// diamonds_ctrl
//
// Shares a single OBJ_SIZE x OBJ_SIZE diamond bitmap among NUM_DIAMONDS diamond
// slots. For each pixel it finds the lowest-index drawable slot that covers the
// pixel. It then drives objectExists plus the pixel offset into that slot for
// the bitmap, and tracks which diamonds the player has collected.
//
// Optional feature macro: DIAMONDS_BLINK_EN
//   defined   : a collected diamond blinks for BLINK_FRAMES frames
//               (drawn on odd counter values) before disappearing.
//   undefined : a collected diamond disappears at the next startOfFrame, and
//               no blink counters are built.
//
// Ports
//   clk, resetN         pixel clock, asynchronous active-low reset
//   startOfFrame        one-cycle pulse at frame start
//   pixelX, pixelY      current pixel
//   newLevel            clear all slots (wins over load and collision)
//   load_valid/ready    slot load handshake; load_idx, load_x, load_y payload
//   collision           player/diamond collision, aligned to bitmap RGBout (t+2)
//   objectExists        registered cover flag to bitmap (t+1)
//   offsetX, offsetY    registered pixel - slot top-left (t+1), 0 when no cover
//   scorePulse          one cycle per diamond collected
//   diamondsLeft        number of ACTIVE slots
//   levelClear          one-cycle pulse when every diamond has been collected
// -----------------------------------------------------------------------------
module diamonds_ctrl #(
    parameter int NUM_DIAMONDS = 8,
    parameter int OBJ_SIZE     = 32,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            startOfFrame,
    input  logic [10:0]                     pixelX,
    input  logic [10:0]                     pixelY,
    input  logic                            newLevel,
    input  logic                            load_valid,
    input  logic [$clog2(NUM_DIAMONDS)-1:0] load_idx,
    input  logic [10:0]                     load_x,
    input  logic [10:0]                     load_y,
    output logic                            load_ready,
    input  logic                            collision,
    output logic                            objectExists,
    output logic [10:0]                     offsetX,
    output logic [10:0]                     offsetY,
    output logic                            scorePulse,
    output logic [4:0]                      diamondsLeft,
    output logic                            levelClear
);

    localparam int IDX_W = $clog2(NUM_DIAMONDS);

    typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_PENDING, S_BLINK} slot_state_t;

    if (NUM_DIAMONDS < 2 || NUM_DIAMONDS > 16 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("diamonds_ctrl: parameter out of range");
    end

    slot_state_t       slot_state [NUM_DIAMONDS];
    slot_state_t       state_nxt  [NUM_DIAMONDS];
    logic [10:0]       slot_x     [NUM_DIAMONDS];
    logic [10:0]       slot_y     [NUM_DIAMONDS];
`ifdef DIAMONDS_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    logic [CNT_W-1:0]  blink_cnt  [NUM_DIAMONDS];
    logic [CNT_W-1:0]  cnt_nxt    [NUM_DIAMONDS];
`endif

    logic [NUM_DIAMONDS-1:0] drawable;
    logic                    armed, armed_nxt;
    logic [4:0]              left_nxt;
    logic                    hit_valid;
    logic [IDX_W-1:0]        hit_idx;
    logic [10:0]             hit_offx, hit_offy;
    logic                    hit_valid_d1, hit_valid_d2;
    logic [IDX_W-1:0]        hit_idx_d1, hit_idx_d2;
    logic                    load_fire, load_inc, coll_apply, clear_fire;

    assign load_ready = !newLevel;

    // A slot is drawn while ACTIVE, while PENDING (collected this frame), and
    // on the odd-counter frames of its blink phase.
    always_comb begin
        for (int i = 0; i < NUM_DIAMONDS; i++) begin
            drawable[i] = (slot_state[i] == S_ACTIVE) || (slot_state[i] == S_PENDING);
`ifdef DIAMONDS_BLINK_EN
            if (slot_state[i] == S_BLINK && blink_cnt[i][0]) drawable[i] = 1'b1;
`endif
        end
    end

    // Cover search. Scanning from the top index down and overwriting leaves the
    // lowest covering index as the winner. Compares are 12 bits wide so a slot
    // near the right/bottom edge never wraps around to cover pixel 0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        hit_valid = 1'b0;
        hit_idx   = '0;
        hit_offx  = '0;
        hit_offy  = '0;
        for (int i = NUM_DIAMONDS - 1; i >= 0; i--) begin
            if (drawable[i] &&
                ({1'b0, pixelX} >= {1'b0, slot_x[i]}) &&
                ({1'b0, pixelX} <  {1'b0, slot_x[i]} + 12'(OBJ_SIZE)) &&
                ({1'b0, pixelY} >= {1'b0, slot_y[i]}) &&
                ({1'b0, pixelY} <  {1'b0, slot_y[i]} + 12'(OBJ_SIZE))) begin
                hit_valid = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_offx  = pixelX - slot_x[i];
                hit_offy  = pixelY - slot_y[i];
            end
        end
    end

    // Slot bookkeeping. Order of precedence: frame-start aging, then the
    // collision, then the load (a load always leaves its slot ACTIVE), and
    // newLevel overrides everything.
    always_comb begin
        load_fire  = load_valid && load_ready;
        coll_apply = collision && hit_valid_d2 && !newLevel &&
                     (slot_state[hit_idx_d2] == S_ACTIVE);
        // A load into the slot being collected this cycle re-activates a slot
        // that the collision has just taken out of the ACTIVE count.
        load_inc   = load_fire && ((slot_state[load_idx] != S_ACTIVE) ||
                                   (coll_apply && (hit_idx_d2 == load_idx)));
        clear_fire = startOfFrame && armed && (diamondsLeft == 5'd0) &&
                     !coll_apply && !newLevel;

        state_nxt = slot_state;
`ifdef DIAMONDS_BLINK_EN
        cnt_nxt   = blink_cnt;
`endif
        if (startOfFrame) begin
            for (int i = 0; i < NUM_DIAMONDS; i++) begin
                case (slot_state[i])
                    S_PENDING: begin
`ifdef DIAMONDS_BLINK_EN
                        state_nxt[i] = S_BLINK;
                        cnt_nxt[i]   = CNT_W'(BLINK_FRAMES);
`else
                        state_nxt[i] = S_EMPTY;
`endif
                    end
                    S_BLINK: begin
`ifdef DIAMONDS_BLINK_EN
                        cnt_nxt[i] = blink_cnt[i] - 1'b1;
                        if (blink_cnt[i] == CNT_W'(1)) state_nxt[i] = S_EMPTY;
`else
                        state_nxt[i] = S_EMPTY;
`endif
                    end
                    default: ;
                endcase
            end
        end
        if (coll_apply) state_nxt[hit_idx_d2] = S_PENDING;
        if (load_fire)  state_nxt[load_idx]   = S_ACTIVE;

        armed_nxt = armed;
        if (clear_fire) armed_nxt = 1'b0;
        if (load_fire)  armed_nxt = 1'b1;

        left_nxt = diamondsLeft + {4'd0, load_inc} - {4'd0, coll_apply};

        if (newLevel) begin
            for (int i = 0; i < NUM_DIAMONDS; i++) state_nxt[i] = S_EMPTY;
            armed_nxt = 1'b0;
            left_nxt  = 5'd0;
        end
    end

    // NOTE: slot coordinates are plain storage, only meaningful once a load
    // has made the slot ACTIVE, so they are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            slot_x[load_idx] <= load_x;
            slot_y[load_idx] <= load_y;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_DIAMONDS; i++) begin
                slot_state[i] <= S_EMPTY;
`ifdef DIAMONDS_BLINK_EN
                blink_cnt[i]  <= '0;
`endif
            end
            armed        <= 1'b0;
            diamondsLeft <= 5'd0;
            scorePulse   <= 1'b0;
            levelClear   <= 1'b0;
            objectExists <= 1'b0;
            offsetX      <= '0;
            offsetY      <= '0;
            hit_valid_d1 <= 1'b0;
            hit_valid_d2 <= 1'b0;
            hit_idx_d1   <= '0;
            hit_idx_d2   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_DIAMONDS; i++) begin
                slot_state[i] <= state_nxt[i];
`ifdef DIAMONDS_BLINK_EN
                blink_cnt[i]  <= cnt_nxt[i];
`endif
            end
            armed        <= armed_nxt;
            diamondsLeft <= left_nxt;
            scorePulse   <= coll_apply;
            levelClear   <= clear_fire;
            objectExists <= hit_valid;
            offsetX      <= hit_offx;
            offsetY      <= hit_offy;
            // Two-stage hit pipeline so hit_*_d2 lines up with collision.
            hit_valid_d1 <= hit_valid;
            hit_idx_d1   <= hit_idx;
            hit_valid_d2 <= hit_valid_d1;
            hit_idx_d2   <= hit_idx_d1;
        end
    end

endmodule
